mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single-port 256 x 8 program/data memory (synchronous write, combinational read). It sits between the memory and its two masters: port 0, the processor fetch/load-store path, and port 1, the program loader/debug path. It serialises their accesses, drives the memory's `addr`/`din`/`we`, and returns registered read data with a one-cycle acknowledge pulse.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the memory port arbiter.
//   state_e   : sequencer state (IDLE, ACCESS, DONE)
//   PORT_CPU  : index of the processor fetch/load-store port (0)
//   PORT_LDR  : index of the program loader/debug port (1)
//   AW_DEF    : default address width (256-entry memory)
//   DW_DEF    : default data width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
//
// Combinational winner select for the two memory ports.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin; on a tie the port other than last_grant wins.
//   undefined : fixed priority; port 0 wins every tie, last_grant is ignored.
//
// Ports:
//   req[1:0]     in   pending requests, bit i = port i
//   last_grant   in   port granted most recently
//   grant_valid  out  at least one request is pending
//   grant        out  index of the winning port (meaningful when grant_valid)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    assign grant_valid = |req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = PORT_CPU;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = PORT_LDR;
        end
    end
`else
    // last_grant is still wired in so both builds share one port list.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = PORT_CPU;
        if (!req[0] && req[1]) begin
            grant = PORT_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-requester arbiter/sequencer for a single-port memory with synchronous
// write and combinational read. Each access takes IDLE -> ACCESS -> DONE.
//
// Handshake: a port raises pN_req with pN_we/pN_addr/pN_wdata stable and
// keeps it high until pN_ack. A request sampled in IDLE is committed; pN_ack
// is a one-cycle pulse in DONE with pN_rdata valid, and requests are not
// sampled in DONE so the requester can drop or change req that cycle.
// A write returns the pre-write contents of the addressed word.
//
// Configuration macro: MEM_ARB_RR_EN (round-robin when defined, otherwise
// fixed priority with port 0 winning ties).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   p0_req/we/addr/wdata       processor port request
//   p1_req/we/addr/wdata       loader/debug port request
//   p0_ack, p1_ack             completion pulses
//   p0_rdata, p1_rdata         registered read data, held between accesses
//   mem_addr, mem_din, mem_we  memory controls (address/data registered)
//   mem_dout                   memory read data
//   busy                       high in ACCESS and DONE
//   owner                      current or most recent grant
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_ack,
    output logic          p1_ack,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          owner
);

    state_e        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic          p0_ack_q, p0_ack_d;
    logic          p1_ack_q, p1_ack_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;

    logic          grant_valid;
    logic          grant;

    mem_arb_pick u_pick (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            we_q         <= 1'b0;
            owner_q      <= PORT_CPU;
            last_grant_q <= PORT_LDR;  // so port 0 wins the first tie
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        p0_ack_d     = p0_ack_q;
        p1_ack_d     = p1_ack_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    mem_addr_d   = (grant == PORT_LDR) ? p1_addr  : p0_addr;
                    mem_din_d    = (grant == PORT_LDR) ? p1_wdata : p0_wdata;
                    we_d         = (grant == PORT_LDR) ? p1_we    : p0_we;
                    owner_d      = grant;
                    last_grant_d = grant;
                end
            end
            ACCESS: begin
                // mem_dout still shows the old word here, so a write
                // returns the pre-write contents.
                if (owner_q == PORT_LDR) begin
                    p1_ack_d   = 1'b1;
                    p1_rdata_d = mem_dout;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = mem_dout;
                end
            end
            DONE: begin
                p0_ack_d = 1'b0;
                p1_ack_d = 1'b0;
            end
            default: begin
                p0_ack_d = 1'b0;
                p1_ack_d = 1'b0;
            end
        endcase
    end

    // Outputs. mem_we is decoded from state so an asynchronous reset
    // drops it before the next edge and aborts the pending write.
    always_comb begin
        mem_we   = (state_q == ACCESS) && we_q;
        busy     = (state_q != IDLE);
        mem_addr = mem_addr_q;
        mem_din  = mem_din_q;
        owner    = owner_q;
        p0_ack   = p0_ack_q;
        p1_ack   = p1_ack_q;
        p0_rdata = p0_rdata_q;
        p1_rdata = p1_rdata_q;
    end

endmodule
